// File: rtl/tx_byte_frame_buffer.sv
// tx_byte_frame_buffer
// Store-and-forward transmit frame buffer. Wide words with byte-keep are
// written in, frames become visible to the read side only once their last
// word is accepted, and committed frames are replayed as a byte stream
// (byte 0 = bits [7:0] first). Aborted or oversized frames are dropped by
// rewinding the write pointer to the start of the frame.
module tx_byte_frame_buffer #(
  parameter int DataWidth = 32,
  parameter int Depth = 512,
  localparam int BytesPerWord = DataWidth / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [DataWidth-1:0]     s_data_i,
  input  logic [BytesPerWord-1:0]  s_keep_i,
  input  logic                     s_last_i,
  input  logic                     s_abort_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [7:0]               m_data_o,
  output logic                     m_last_o,
  output logic [$clog2(Depth):0]   frames_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(BytesPerWord);
  localparam int EW = DataWidth + BytesPerWord + 1;

  localparam logic W_FILL    = 1'b0;
  localparam logic W_DISCARD = 1'b1;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_FETCH  = 2'd1;
  localparam logic [1:0] R_STREAM = 2'd2;

  logic [PW-1:0] wr_ptr, fs_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0] used, next_rd;
  logic          w_state;
  logic [1:0]    r_state;
  logic [IW-1:0] idx, top_idx;
  logic          full, overflow, s_fire, wr_en, commit;
  logic          m_fire, final_byte, word_done, frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    cur_byte;

  logic [EW-1:0] mem [0:Depth-1];
  logic [EW-1:0] rd_q;

  logic [DataWidth-1:0]    hold_data;
  logic [BytesPerWord-1:0] hold_keep;
  logic                    hold_last;

  // The RAM output register doubles as the holding register for the word
  // being streamed, which is what allows a zero-bubble word reload.
  assign hold_data = rd_q[DataWidth-1:0];
  assign hold_keep = rd_q[DataWidth +: BytesPerWord];
  assign hold_last = rd_q[EW-1];

  assign used     = wr_ptr - rd_ptr;
  assign full     = (used == PW'(Depth));
  assign overflow = (w_state == W_FILL) && full && (fs_ptr == rd_ptr);
  assign s_ready_o = (w_state == W_DISCARD) || !full;
  assign s_fire    = s_valid_i && s_ready_o;
  assign wr_en     = s_fire && (w_state == W_FILL);
  assign commit    = wr_en && s_last_i && !s_abort_i;
  assign level_o   = used;

  assign next_rd    = rd_ptr + PW'(1);
  assign m_valid_o  = (r_state == R_STREAM);
  assign final_byte = hold_last ? (idx == top_idx) : (idx == IW'(BytesPerWord - 1));
  assign m_last_o   = m_valid_o && hold_last && (idx == top_idx);
  assign m_data_o   = m_valid_o ? cur_byte : 8'h00;
  assign m_fire     = m_valid_o && m_ready_i;
  assign word_done  = m_fire && final_byte;
  assign frame_done = m_fire && m_last_o;

  assign rd_en   = ((r_state == R_IDLE) && (rd_ptr != cm_ptr)) ||
                   (word_done && (next_rd != cm_ptr));
  assign rd_addr = (r_state == R_IDLE) ? rd_ptr[AW-1:0] : next_rd[AW-1:0];

  // Pick the highest set keep bit and the byte lane currently being shown.
  always_comb begin
    top_idx  = '0;
    cur_byte = '0;
    for (int b = 0; b < BytesPerWord; b++) begin
      if (hold_keep[b]) top_idx = IW'(b);
      if (idx == IW'(b)) cur_byte = hold_data[b*8 +: 8];
    end
  end

  // Behavioural single-clock RAM with registered read, replaceable by a macro.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_last_i, s_keep_i, s_data_i};
    if (rd_en) rd_q <= mem[rd_addr];
  end

  // Write side: fill, commit, abort rewind and whole-frame overflow discard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      fs_ptr  <= '0;
      cm_ptr  <= '0;
      w_state <= W_FILL;
      drop_o  <= 1'b0;
    end else begin
      drop_o <= 1'b0;
      if (w_state == W_FILL) begin
        if (overflow) begin
          wr_ptr  <= fs_ptr;
          drop_o  <= 1'b1;
          w_state <= W_DISCARD;
        end else if (wr_en) begin
          if (s_last_i && s_abort_i) begin
            wr_ptr <= fs_ptr;
            drop_o <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + PW'(1);
            if (s_last_i) begin
              fs_ptr <= wr_ptr + PW'(1);
              cm_ptr <= wr_ptr + PW'(1);
            end
          end
        end
      end else if (s_fire && s_last_i) begin
        w_state <= W_FILL;
      end
    end
  end

  // Read side: fetch committed words and walk their bytes out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr  <= '0;
      idx     <= '0;
      r_state <= R_IDLE;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_ptr != cm_ptr) r_state <= R_FETCH;
        end
        R_FETCH: begin
          idx     <= '0;
          r_state <= R_STREAM;
        end
        R_STREAM: begin
          if (m_fire) begin
            if (final_byte) begin
              rd_ptr <= next_rd;
              idx    <= '0;
              if (next_rd == cm_ptr) r_state <= R_IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Committed-but-unread frame count; a commit and a frame end cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frames_o <= '0;
    end else begin
      case ({commit, frame_done})
        2'b10:   frames_o <= frames_o + PW'(1);
        2'b01:   frames_o <= frames_o - PW'(1);
        default: frames_o <= frames_o;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_byte_frame_buffer.sv
// tb_tx_byte_frame_buffer
// Self-checking bench: a scoreboard queue of expected {last, byte} entries is
// filled as frames are written and drained by a monitor on the output side.
module tb_tx_byte_frame_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int PW = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic [3:0]    s_keep_i = '0;
  logic          s_last_i = 1'b0;
  logic          s_abort_i = 1'b0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [7:0]    m_data_o;
  logic          m_last_o;
  logic [PW-1:0] frames_o;
  logic [PW-1:0] level_o;
  logic          drop_o;

  int checks = 0;
  int failures = 0;
  int bytes_seen = 0;
  int drops_seen = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  typedef struct {
    int   nbytes;
    logic abort;
    int   exp_bytes;
    int   exp_drops;
  } vec_t;

  vec_t vecs[10];

  tx_byte_frame_buffer #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_keep_i(s_keep_i), .s_last_i(s_last_i), .s_abort_i(s_abort_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .frames_o(frames_o), .level_o(level_o), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Output monitor: every handshaken byte is compared against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (drop_o) drops_seen++;
      if (m_valid_o && m_ready_i) begin
        bytes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte: actual=0x%0h required=none", {m_last_o, m_data_o});
        end else begin
          mon_exp = exp_q.pop_front();
          check_output("byte_out", 32'({m_last_o, m_data_o}), 32'(mon_exp));
        end
      end
    end
  end

  function automatic logic [31:0] make_word(input logic [7:0] seed, input int w);
    logic [31:0] d;
    for (int b = 0; b < 4; b++) d[b*8 +: 8] = seed + 8'(w * 4 + b);
    return d;
  endfunction

  function automatic logic [3:0] keep_for(input int rem);
    return 4'((1 << rem) - 1);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [31:0] data, input logic [3:0] keep, input logic last, input logic abort);
    int waited;
    waited = 0;
    s_valid_i = 1'b1;
    s_data_i  = data;
    s_keep_i  = keep;
    s_last_i  = last;
    s_abort_i = abort;
    while (!s_ready_o && waited < 100) begin
      tick();
      waited++;
    end
    if (!s_ready_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL write_timeout: actual=stalled required=accepted");
    end
    tick();
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_abort_i = 1'b0;
  endtask

  task automatic push_expected(input int nbytes, input logic [7:0] seed);
    for (int i = 0; i < nbytes; i++)
      exp_q.push_back({(i == nbytes - 1), 8'(seed + 8'(i))});
  endtask

  task automatic send_frame(input int nbytes, input logic abort, input bit expect_out, input logic [7:0] seed);
    int words;
    words = (nbytes + 3) / 4;
    for (int w = 0; w < words; w++) begin
      if (w == words - 1) push_word(make_word(seed, w), keep_for(nbytes - w * 4), 1'b1, abort);
      else push_word(make_word(seed, w), 4'hF, 1'b0, 1'b0);
    end
    if (expect_out) push_expected(nbytes, seed);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (n < 300 && !(exp_q.size() == 0 && level_o == 0 && !m_valid_o)) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_drain_timeout: actual=%0d pending required=0", name, exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic apply_stimulus(input vec_t v, input int row);
    int b0, d0;
    b0 = bytes_seen;
    d0 = drops_seen;
    send_frame(v.nbytes, v.abort, v.exp_bytes != 0, 8'(row * 37 + 5));
    wait_drain("table");
    check_output("table_bytes", 32'(bytes_seen - b0), 32'(v.exp_bytes));
    check_output("table_drops", 32'(drops_seen - d0), 32'(v.exp_drops));
    check_output("table_frames", 32'(frames_o), 32'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, streak, b0, d0;

    vecs[0] = '{1, 1'b0, 1, 0};
    vecs[1] = '{2, 1'b0, 2, 0};
    vecs[2] = '{3, 1'b0, 3, 0};
    vecs[3] = '{4, 1'b0, 4, 0};
    vecs[4] = '{5, 1'b0, 5, 0};
    vecs[5] = '{14, 1'b0, 14, 0};
    vecs[6] = '{6, 1'b1, 0, 1};
    vecs[7] = '{1, 1'b1, 0, 1};
    vecs[8] = '{32, 1'b0, 32, 0};
    vecs[9] = '{33, 1'b0, 0, 1};

    // Reset values.
    tick();
    tick();
    check_output("rst_s_ready", 32'(s_ready_o), 32'd1);
    check_output("rst_m_valid", 32'(m_valid_o), 32'd0);
    check_output("rst_m_data", 32'(m_data_o), 32'd0);
    check_output("rst_m_last", 32'(m_last_o), 32'd0);
    check_output("rst_frames", 32'(frames_o), 32'd0);
    check_output("rst_level", 32'(level_o), 32'd0);
    check_output("rst_drop", 32'(drop_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Table-driven frames with the output always ready.
    m_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], i);

    // 9-byte frame: latency from commit and frame count.
    send_frame(9, 1'b0, 1'b1, 8'h10);
    check_output("t9_frames_one", 32'(frames_o), 32'd1);
    lat = 0;
    while (!m_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check_output("t9_latency", 32'(lat), 32'd2);
    wait_drain("t9");
    check_output("t9_frames_zero", 32'(frames_o), 32'd0);

    // Two 8-byte frames stacked up, then streamed with no bubble.
    m_ready_i = 1'b0;
    send_frame(8, 1'b0, 1'b1, 8'h40);
    send_frame(8, 1'b0, 1'b1, 8'h80);
    tick();
    tick();
    check_output("b2b_frames", 32'(frames_o), 32'd2);
    check_output("b2b_level", 32'(level_o), 32'd4);
    m_ready_i = 1'b1;
    streak = 0;
    for (int c = 0; c < 16; c++) begin
      if (m_valid_o) streak++;
      tick();
    end
    check_output("b2b_streak", 32'(streak), 32'd16);
    check_output("b2b_idle_after", 32'(m_valid_o), 32'd0);
    wait_drain("b2b");

    // Abort while another frame sits committed.
    m_ready_i = 1'b0;
    send_frame(1, 1'b0, 1'b1, 8'hA0);
    d0 = drops_seen;
    b0 = bytes_seen;
    send_frame(6, 1'b1, 1'b0, 8'hB0);
    check_output("abort_drop_pulse", 32'(drop_o), 32'd1);
    tick();
    check_output("abort_drop_low", 32'(drop_o), 32'd0);
    check_output("abort_level", 32'(level_o), 32'd1);
    check_output("abort_frames", 32'(frames_o), 32'd1);
    m_ready_i = 1'b1;
    wait_drain("abort");
    check_output("abort_drop_count", 32'(drops_seen - d0), 32'd1);
    check_output("abort_bytes", 32'(bytes_seen - b0), 32'd1);

    // Oversized 10-word frame is dropped, the following frame survives.
    d0 = drops_seen;
    b0 = bytes_seen;
    send_frame(40, 1'b0, 1'b0, 8'hC0);
    tick();
    check_output("ovf_level", 32'(level_o), 32'd0);
    check_output("ovf_frames", 32'(frames_o), 32'd0);
    send_frame(6, 1'b0, 1'b1, 8'hD0);
    wait_drain("ovf");
    check_output("ovf_drop_count", 32'(drops_seen - d0), 32'd1);
    check_output("ovf_bytes", 32'(bytes_seen - b0), 32'd6);

    // Backpressure: six committed words plus two more fill the buffer.
    m_ready_i = 1'b0;
    d0 = drops_seen;
    send_frame(24, 1'b0, 1'b1, 8'h20);
    check_output("bp_level6", 32'(level_o), 32'd6);
    push_word(make_word(8'h60, 0), 4'hF, 1'b0, 1'b0);
    push_word(make_word(8'h60, 1), 4'hF, 1'b0, 1'b0);
    check_output("bp_level8", 32'(level_o), 32'd8);
    check_output("bp_ready_low", 32'(s_ready_o), 32'd0);
    tick();
    for (int p = 0; p < 4; p++) begin
      m_ready_i = 1'b1;
      tick();
      m_ready_i = 1'b0;
      if (p == 2) check_output("bp_ready_after3", 32'(s_ready_o), 32'd0);
      if (p == 3) begin
        check_output("bp_ready_after4", 32'(s_ready_o), 32'd1);
        check_output("bp_level7", 32'(level_o), 32'd7);
      end
      tick();
    end
    check_output("bp_no_drop", 32'(drops_seen - d0), 32'd0);
    push_word(make_word(8'h60, 2), 4'h3, 1'b1, 1'b0);
    push_expected(10, 8'h60);
    m_ready_i = 1'b1;
    wait_drain("bp");

    // Reset in the middle of streaming a frame.
    send_frame(8, 1'b0, 1'b1, 8'hE0);
    lat = 0;
    while (!m_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check_output("mid_rst_m_valid", 32'(m_valid_o), 32'd0);
    check_output("mid_rst_frames", 32'(frames_o), 32'd0);
    check_output("mid_rst_level", 32'(level_o), 32'd0);
    check_output("mid_rst_s_ready", 32'(s_ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();
    b0 = bytes_seen;
    send_frame(5, 1'b0, 1'b1, 8'h33);
    wait_drain("post_rst");
    check_output("post_rst_bytes", 32'(bytes_seen - b0), 32'd5);
    check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
